// File: rtl/instr_sequencer.sv
// Program-driven control sequencer: fetches 16-bit instruction words over valid/ready,
// decodes them and drives the register-file/ALU control bundle, one instruction at a time.
module instr_sequencer #(
   parameter int                     PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      InstrValid,
   input  logic [15:0]               InstrData,
   output logic                      InstrReady,
   output logic [PC_WIDTH-1:0]       PC,
   output logic [3:0]                RdestRegLoc,
   output logic [3:0]                RsrcRegLoc,
   output logic [3:0]                OpCode,
   output logic [15:0]               Imm,
   output logic                      Imm_s,
   output logic                      En,
   output logic                      Halted,
   output logic [2:0]                DbgState
);

   // Handshake: a word is transferred on the rising edge where InstrValid and
   // InstrReady are both 1; InstrReady is high only in FETCH and never depends on InstrValid.

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_pc_nxt;
   logic [15:0]         r_ir;
   logic [15:0]         w_ir_nxt;
   logic [3:0]          r_rdest;
   logic [3:0]          w_rdest_nxt;
   logic [3:0]          r_rsrc;
   logic [3:0]          w_rsrc_nxt;
   logic [3:0]          r_opcode;
   logic [3:0]          w_opcode_nxt;
   logic [15:0]         r_imm;
   logic [15:0]         w_imm_nxt;
   logic                r_imm_s;
   logic                w_imm_s_nxt;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state  <= S_IDLE;
         r_pc     <= RESET_PC;
         r_ir     <= '0;
         r_rdest  <= '0;
         r_rsrc   <= '0;
         r_opcode <= '0;
         r_imm    <= '0;
         r_imm_s  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_ir     <= w_ir_nxt;
         r_rdest  <= w_rdest_nxt;
         r_rsrc   <= w_rsrc_nxt;
         r_opcode <= w_opcode_nxt;
         r_imm    <= w_imm_nxt;
         r_imm_s  <= w_imm_s_nxt;
      end
   end

   // Fields are loaded on the accepting edge so they are already settled during DECODE
   // and stay untouched through EXEC; HALT/NOP words leave them as they were.
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_ir_nxt     = r_ir;
      w_rdest_nxt  = r_rdest;
      w_rsrc_nxt   = r_rsrc;
      w_opcode_nxt = r_opcode;
      w_imm_nxt    = r_imm;
      w_imm_s_nxt  = r_imm_s;
      case (r_state)
         S_IDLE: w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (InstrValid) begin
               w_ir_nxt    = InstrData;
               w_pc_nxt    = r_pc + PC_WIDTH'(1);
               w_state_nxt = S_DECODE;
               if (InstrData[15:12] == 4'b0000) begin
                  w_opcode_nxt = InstrData[7:4];
                  w_rdest_nxt  = InstrData[11:8];
                  w_rsrc_nxt   = InstrData[3:0];
                  w_imm_nxt    = '0;
                  w_imm_s_nxt  = 1'b0;
               end else if (InstrData[15:12] != 4'b1111) begin
                  w_opcode_nxt = InstrData[15:12];
                  w_rdest_nxt  = InstrData[11:8];
                  w_rsrc_nxt   = '0;
                  w_imm_nxt    = {{8{InstrData[7]}}, InstrData[7:0]};
                  w_imm_s_nxt  = 1'b1;
               end
            end
         end
         S_DECODE: begin
            if (r_ir[15:12] != 4'b1111)    w_state_nxt = S_EXEC;
            else if (r_ir[7:4] == 4'b0000) w_state_nxt = S_HALT;
            else                           w_state_nxt = S_FETCH;
         end
         S_EXEC:  w_state_nxt = S_FETCH;
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign InstrReady  = (r_state == S_FETCH);
   assign En          = (r_state == S_EXEC);
   assign Halted      = (r_state == S_HALT);
   assign PC          = r_pc;
   assign RdestRegLoc = r_rdest;
   assign RsrcRegLoc  = r_rsrc;
   assign OpCode      = r_opcode;
   assign Imm         = r_imm;
   assign Imm_s       = r_imm_s;
   assign DbgState    = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: vector table for ALU decode plus hand-written
// sequences for stalls, NOP/HALT, PC wrap and asynchronous reset mid-EXEC.
module tb_instr_sequencer;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        InstrValid = 1'b0;
   logic [15:0] InstrData = 16'h0000;
   logic        InstrReady;
   logic [15:0] PC;
   logic [3:0]  RdestRegLoc, RsrcRegLoc, OpCode;
   logic [15:0] Imm;
   logic        Imm_s, En, Halted;
   logic [2:0]  DbgState;

   logic        wr_valid = 1'b0;
   logic [15:0] wr_data = 16'h0000;
   logic        wr_ready;
   logic [15:0] wr_pc;
   logic [3:0]  wr_rdest, wr_rsrc, wr_op;
   logic [15:0] wr_imm;
   logic        wr_imm_s, wr_en, wr_halted;
   logic [2:0]  wr_state;

   int n_pass = 0;
   int n_total = 0;
   logic [15:0] exp_pc;

   typedef struct {
      logic [15:0] instr;
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic [15:0] imm;
      logic        imm_s;
   } vec_t;

   vec_t vecs[5];
   vec_t last_v;

   always #5 Clk = ~Clk;

   instr_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) u_dut (
      .Clk(Clk), .Rst(Rst), .InstrValid(InstrValid), .InstrData(InstrData),
      .InstrReady(InstrReady), .PC(PC), .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc),
      .OpCode(OpCode), .Imm(Imm), .Imm_s(Imm_s), .En(En), .Halted(Halted), .DbgState(DbgState)
   );

   instr_sequencer #(.PC_WIDTH(16), .RESET_PC(16'hFFFF)) u_wrap (
      .Clk(Clk), .Rst(Rst), .InstrValid(wr_valid), .InstrData(wr_data),
      .InstrReady(wr_ready), .PC(wr_pc), .RdestRegLoc(wr_rdest), .RsrcRegLoc(wr_rsrc),
      .OpCode(wr_op), .Imm(wr_imm), .Imm_s(wr_imm_s), .En(wr_en), .Halted(wr_halted),
      .DbgState(wr_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_fields(input string tag, input vec_t v);
      check({tag, "_op"},    32'(OpCode),      32'(v.op));
      check({tag, "_rd"},    32'(RdestRegLoc), 32'(v.rd));
      check({tag, "_rs"},    32'(RsrcRegLoc),  32'(v.rs));
      check({tag, "_imm"},   32'(Imm),         32'(v.imm));
      check({tag, "_imm_s"}, 32'(Imm_s),       32'(v.imm_s));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"},  32'(DbgState),   32'(ST_IDLE));
      check({tag, "_pc"},     32'(PC),         32'h0);
      check({tag, "_ready"},  32'(InstrReady), 32'h0);
      check({tag, "_en"},     32'(En),         32'h0);
      check({tag, "_halted"}, 32'(Halted),     32'h0);
      check({tag, "_ctl"},    {OpCode, RdestRegLoc, RsrcRegLoc, 3'b0, Imm_s, Imm},
            32'h0);
   endtask

   // Push one word during FETCH; returns at the negedge after the handshake (DECODE).
   task automatic push_word(input string tag, input logic [15:0] w);
      check({tag, "_pre_state"}, 32'(DbgState), 32'(ST_FETCH));
      check({tag, "_pre_ready"}, 32'(InstrReady), 32'h1);
      InstrValid = 1'b1;
      InstrData  = w;
      @(negedge Clk);
      InstrValid = 1'b0;
      InstrData  = 16'($urandom_range(0, 16'hFFFF));
      exp_pc     = exp_pc + 16'h1;
   endtask

   task automatic run_alu(input string tag, input vec_t v);
      push_word(tag, v.instr);
      check({tag, "_dec_state"}, 32'(DbgState), 32'(ST_DECODE));
      check({tag, "_dec_en"},    32'(En),       32'h0);
      check({tag, "_dec_ready"}, 32'(InstrReady), 32'h0);
      check({tag, "_pc"},        32'(PC),       32'(exp_pc));
      check_fields({tag, "_dec"}, v);
      @(negedge Clk);
      check({tag, "_exe_state"}, 32'(DbgState), 32'(ST_EXEC));
      check({tag, "_exe_en"},    32'(En),       32'h1);
      check_fields({tag, "_exe"}, v);
      @(negedge Clk);
      check({tag, "_post_state"}, 32'(DbgState), 32'(ST_FETCH));
      check({tag, "_post_en"},    32'(En),       32'h0);
      check_fields({tag, "_post"}, v);
      last_v = v;
   endtask

   initial begin
      vecs[0] = '{instr: 16'h1305, op: 4'h1, rd: 4'h3, rs: 4'h0, imm: 16'h0005, imm_s: 1'b1};
      vecs[1] = '{instr: 16'h0201, op: 4'h0, rd: 4'h2, rs: 4'h1, imm: 16'h0000, imm_s: 1'b0};
      vecs[2] = '{instr: 16'h14FE, op: 4'h1, rd: 4'h4, rs: 4'h0, imm: 16'hFFFE, imm_s: 1'b1};
      vecs[3] = '{instr: 16'h0A3C, op: 4'h3, rd: 4'hA, rs: 4'hC, imm: 16'h0000, imm_s: 1'b0};
      vecs[4] = '{instr: 16'hEB80, op: 4'hE, rd: 4'hB, rs: 4'h0, imm: 16'hFF80, imm_s: 1'b1};
      exp_pc = 16'h0;

      repeat (3) @(negedge Clk);
      check_reset_outputs("reset");
      check("wrap_reset_pc", 32'(wr_pc), 32'hFFFF);
      Rst = 1'b1;
      @(negedge Clk);
      check("first_fetch_state", 32'(DbgState), 32'(ST_FETCH));
      check("first_fetch_ready", 32'(InstrReady), 32'h1);

      // PC wrap on the instance reset to the top of the address space.
      check("wrap_pre_ready", 32'(wr_ready), 32'h1);
      wr_valid = 1'b1;
      wr_data  = 16'h1305;
      @(negedge Clk);
      wr_valid = 1'b0;
      check("wrap_pc", 32'(wr_pc), 32'h0000);
      check("wrap_state", 32'(wr_state), 32'(ST_DECODE));
      check("wrap_op", 32'(wr_op), 32'h1);
      check("idle_fetch_pc", 32'(PC), 32'h0);

      for (int i = 0; i < 5; i++) run_alu($sformatf("vec%0d", i), vecs[i]);

      // Stall: no valid for 5 cycles.
      for (int i = 0; i < 5; i++) begin
         InstrData = 16'($urandom_range(0, 16'hFFFF));
         @(negedge Clk);
         check($sformatf("stall%0d_ready", i), 32'(InstrReady), 32'h1);
         check($sformatf("stall%0d_pc", i), 32'(PC), 32'(exp_pc));
         check($sformatf("stall%0d_en", i), 32'(En), 32'h0);
      end
      run_alu("after_stall", vecs[0]);

      // NOP: two cycles, no write, controls held.
      push_word("nop", 16'hF010);
      check("nop_dec_state", 32'(DbgState), 32'(ST_DECODE));
      check("nop_dec_en", 32'(En), 32'h0);
      check_fields("nop_hold", last_v);
      @(negedge Clk);
      check("nop_ret_state", 32'(DbgState), 32'(ST_FETCH));
      check("nop_ret_en", 32'(En), 32'h0);

      // HALT: frozen until reset, even with valid words offered.
      push_word("halt", 16'hF000);
      check("halt_dec_en", 32'(En), 32'h0);
      check_fields("halt_hold", last_v);
      InstrValid = 1'b1;
      InstrData  = 16'h0201;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         check($sformatf("halt%0d", i), {Halted, InstrReady, En, 13'b0, PC},
               {1'b1, 1'b0, 1'b0, 13'b0, exp_pc});
      end
      InstrValid = 1'b0;
      check("halt_pc_value", 32'(PC), 32'h8);

      // Reset exits HALT.
      Rst = 1'b0;
      #1;
      check_reset_outputs("halt_rst");
      @(negedge Clk);
      Rst = 1'b1;
      exp_pc = 16'h0;
      @(negedge Clk);
      check("rst_refetch_state", 32'(DbgState), 32'(ST_FETCH));

      // Asynchronous reset in the middle of EXEC.
      push_word("async", 16'h1305);
      @(negedge Clk);
      check("async_exec_en", 32'(En), 32'h1);
      #2;
      Rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge Clk);
      check_reset_outputs("async_hold");
      Rst = 1'b1;
      exp_pc = 16'h0;
      @(negedge Clk);
      check("async_restart_state", 32'(DbgState), 32'(ST_FETCH));
      run_alu("restart", vecs[1]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
